// File: rtl/bist_seq_pkg.sv
// Shared definitions for the BIST run sequencer: state encoding and a width helper.
package bist_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_CHECK  = 3'd2,
    ST_GAP    = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  // Bits needed to hold 0..value-1, never less than 1.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bist_watchdog.sv
// Clear/enable up-counter whose registered expire flag is high while the count sits at LIMIT-1.
module bist_watchdog
  import bist_seq_pkg::*;
#(
  parameter int LIMIT = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int W = clog2(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] r_cnt;
  logic         r_exp;

  // The flag is precomputed one edge ahead so the FSM sees it in the LIMIT-th enabled cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
      r_exp <= (LIMIT == 1);
    end else if (i_en && !r_exp) begin
      r_cnt <= r_cnt + 1'b1;
      r_exp <= ((r_cnt + 1'b1) == LAST);
    end
  end

  assign o_expire = r_exp;

endmodule

// File: rtl/bist_run_sequencer.sv
// Runs the BIST engine for a programmed number of passes, counting passes and failures,
// with a per-pass watchdog and a fixed low gap between passes.
module bist_run_sequencer
  import bist_seq_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int TIMEOUT_CYC  = 1024,
  parameter int GAP_CYC      = 2,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic             clk,
  input  logic             TLR,
  input  logic             START,
  input  logic             ABORT,
  input  logic [CNT_W-1:0] PASS_LIMIT,
  input  logic             BIST_DONE,
  input  logic             BIST_ERROR,
  output logic             RUNBIST_SELECT,
  output logic             BUSY,
  output logic             DONE,
  output logic             FAIL,
  output logic             TIMEOUT,
  output logic [CNT_W-1:0] PASS_CNT,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic [2:0]       o_dbg_state
);

  // Control interface: START and ABORT are single-cycle level requests sampled on every
  // edge with no handshake back; START is taken only in IDLE without ABORT, ABORT only
  // when busy. BIST_DONE is a level from the engine, acted on only in RUN.

  state_e           r_state;
  state_e           w_next;
  logic             r_sel;
  logic             r_done;
  logic             r_fail;
  logic             r_timeout;
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_limit;
  logic             r_pass_err;

  logic             w_wd_exp;
  logic             w_gap_exp;
  logic             w_start_ok;
  logic             w_pass_bad;
  logic [CNT_W-1:0] w_pass_next;
  logic             w_seq_end;
  logic             w_timeout_hit;

  bist_watchdog #(.LIMIT(TIMEOUT_CYC)) u_run_wd (
    .i_clk    (clk),
    .i_rst    (TLR),
    .i_clr    (r_state != ST_RUN),
    .i_en     (r_state == ST_RUN),
    .o_expire (w_wd_exp)
  );

  bist_watchdog #(.LIMIT(GAP_CYC)) u_gap_tmr (
    .i_clk    (clk),
    .i_rst    (TLR),
    .i_clr    (r_state != ST_GAP),
    .i_en     (r_state == ST_GAP),
    .o_expire (w_gap_exp)
  );

  assign w_start_ok    = START && !ABORT;
  assign w_pass_bad    = r_pass_err | BIST_ERROR;
  assign w_pass_next   = r_pass_cnt + 1'b1;
  assign w_seq_end     = ((r_limit != '0) && (w_pass_next == r_limit)) ||
                         ((STOP_ON_FAIL != 0) && w_pass_bad);
  // BIST_DONE on the expiry edge wins, so the pass is checked rather than timed out.
  assign w_timeout_hit = (r_state == ST_RUN) && !ABORT && !BIST_DONE && w_wd_exp;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_start_ok) w_next = ST_RUN;
      ST_RUN: begin
        if (ABORT)          w_next = ST_FINISH;
        else if (BIST_DONE) w_next = ST_CHECK;
        else if (w_wd_exp)  w_next = ST_FINISH;
      end
      ST_CHECK:  w_next = (ABORT || w_seq_end) ? ST_FINISH : ST_GAP;
      ST_GAP: begin
        if (ABORT)          w_next = ST_FINISH;
        else if (w_gap_exp) w_next = ST_RUN;
      end
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (TLR) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (TLR) begin
      r_sel      <= 1'b0;
      r_done     <= 1'b0;
      r_fail     <= 1'b0;
      r_timeout  <= 1'b0;
      r_pass_cnt <= '0;
      r_err_cnt  <= '0;
      r_limit    <= '0;
      r_pass_err <= 1'b0;
    end else begin
      r_sel  <= (w_next == ST_RUN);
      r_done <= (r_state == ST_FINISH);
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_limit    <= PASS_LIMIT;
            r_pass_cnt <= '0;
            r_err_cnt  <= '0;
            r_fail     <= 1'b0;
            r_timeout  <= 1'b0;
            r_pass_err <= 1'b0;
          end
        end
        ST_RUN: begin
          r_pass_err <= r_pass_err | BIST_ERROR;
          if (w_timeout_hit) begin
            r_timeout <= 1'b1;
            r_fail    <= 1'b1;
          end
        end
        ST_CHECK: begin
          // A pass that reached CHECK is counted even if ABORT arrives in this cycle.
          r_pass_cnt <= w_pass_next;
          r_pass_err <= 1'b0;
          if (w_pass_bad) begin
            r_fail <= 1'b1;
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign RUNBIST_SELECT = r_sel;
  assign BUSY           = (r_state != ST_IDLE);
  assign DONE           = r_done;
  assign FAIL           = r_fail;
  assign TIMEOUT        = r_timeout;
  assign PASS_CNT       = r_pass_cnt;
  assign ERR_CNT        = r_err_cnt;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_bist_run_sequencer.sv
// Bench for bist_run_sequencer: three parameterisations driven side by side, each with
// its own engine responder and a sequence-level reference model checked every cycle.
module tb_bist_run_sequencer;

  localparam int N        = 3;
  localparam int PH_IDLE  = 0;
  localparam int PH_RUN   = 1;
  localparam int PH_CHECK = 2;
  localparam int PH_GAP   = 3;
  localparam int PH_FIN   = 4;

  // ---------------- clock / reset / DUT inputs ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         tlr, start, abort;
  logic [7:0]   plimit;
  logic [1:0]   plim2;
  logic [N-1:0] bd, be, sel, busy, dn, fl, tm;
  logic [7:0]   pc0, ec0, pc1, ec1;
  logic [1:0]   pc2, ec2;
  logic [2:0]   st0, st1, st2;

  bist_run_sequencer #(.CNT_W(8), .TIMEOUT_CYC(16), .GAP_CYC(2), .STOP_ON_FAIL(0)) dut0 (
    .clk(clk), .TLR(tlr), .START(start), .ABORT(abort), .PASS_LIMIT(plimit),
    .BIST_DONE(bd[0]), .BIST_ERROR(be[0]), .RUNBIST_SELECT(sel[0]), .BUSY(busy[0]),
    .DONE(dn[0]), .FAIL(fl[0]), .TIMEOUT(tm[0]), .PASS_CNT(pc0), .ERR_CNT(ec0),
    .o_dbg_state(st0));

  bist_run_sequencer #(.CNT_W(8), .TIMEOUT_CYC(16), .GAP_CYC(2), .STOP_ON_FAIL(1)) dut1 (
    .clk(clk), .TLR(tlr), .START(start), .ABORT(abort), .PASS_LIMIT(plimit),
    .BIST_DONE(bd[1]), .BIST_ERROR(be[1]), .RUNBIST_SELECT(sel[1]), .BUSY(busy[1]),
    .DONE(dn[1]), .FAIL(fl[1]), .TIMEOUT(tm[1]), .PASS_CNT(pc1), .ERR_CNT(ec1),
    .o_dbg_state(st1));

  bist_run_sequencer #(.CNT_W(2), .TIMEOUT_CYC(12), .GAP_CYC(3), .STOP_ON_FAIL(0)) dut2 (
    .clk(clk), .TLR(tlr), .START(start), .ABORT(abort), .PASS_LIMIT(plim2),
    .BIST_DONE(bd[2]), .BIST_ERROR(be[2]), .RUNBIST_SELECT(sel[2]), .BUSY(busy[2]),
    .DONE(dn[2]), .FAIL(fl[2]), .TIMEOUT(tm[2]), .PASS_CNT(pc2), .ERR_CNT(ec2),
    .o_dbg_state(st2));

  function automatic int p_to(input int k);   return (k == 2) ? 12 : 16; endfunction
  function automatic int p_gap(input int k);  return (k == 2) ? 3 : 2;   endfunction
  function automatic bit p_stop(input int k); return (k == 1);           endfunction
  function automatic int p_max(input int k);  return (k == 2) ? 3 : 255; endfunction

  function automatic int act_pc(input int k);
    case (k) 0: return int'(pc0); 1: return int'(pc1); default: return int'(pc2); endcase
  endfunction
  function automatic int act_ec(input int k);
    case (k) 0: return int'(ec0); 1: return int'(ec1); default: return int'(ec2); endcase
  endfunction
  function automatic int act_st(input int k);
    case (k) 0: return int'(st0); 1: return int'(st1); default: return int'(st2); endcase
  endfunction

  // ---------------- engine responder ----------------
  int          eng_len;      // 0: never reports done
  logic [31:0] bad_mask;     // bit i: pass i raises BIST_ERROR once
  bit          noise;        // random done/error while select is low
  int          eng_epoch;
  int          seen_epoch;
  int          eng_age[N], eng_pass[N], err_at[N];
  bit          prev_sel[N];

  always @(negedge clk) begin
    if (seen_epoch != eng_epoch) begin
      seen_epoch = eng_epoch;
      for (int k = 0; k < N; k++) eng_pass[k] = 0;
    end
    for (int k = 0; k < N; k++) begin
      if (sel[k]) begin
        if (!prev_sel[k]) begin
          eng_age[k] = 0;
          err_at[k]  = int'($urandom_range(1, (eng_len == 0) ? 8 : eng_len));
        end
        eng_age[k]++;
        bd[k] = (eng_len != 0) && (eng_age[k] >= eng_len);
        be[k] = (eng_pass[k] < 32) && bad_mask[eng_pass[k][4:0]] && (eng_age[k] == err_at[k]);
      end else begin
        if (prev_sel[k]) eng_pass[k]++;
        eng_age[k] = 0;
        bd[k] = noise && ($urandom_range(0, 3) == 0);
        be[k] = noise && ($urandom_range(0, 5) == 0);
      end
      prev_sel[k] = sel[k];
    end
  end

  // ---------------- reference model ----------------
  int m_ph[N], m_age[N], m_gn[N], m_lim[N], m_pc[N], m_ec[N];
  bit m_fail[N], m_tmo[N], m_perr[N], m_done[N];

  int checks;
  int failures;
  int sel_hi_cnt;
  int done_cnt;

  task automatic model_update();
    for (int k = 0; k < N; k++) begin
      if (tlr) begin
        m_ph[k] = PH_IDLE; m_age[k] = 0; m_gn[k] = 0; m_lim[k] = 0; m_pc[k] = 0; m_ec[k] = 0;
        m_fail[k] = 0; m_tmo[k] = 0; m_perr[k] = 0; m_done[k] = 0;
      end else begin
        int ph;
        bit bad;
        ph        = m_ph[k];
        m_done[k] = (ph == PH_FIN);
        case (ph)
          PH_IDLE: if (start && !abort) begin
            m_lim[k] = (k == 2) ? int'(plim2) : int'(plimit);
            m_pc[k] = 0; m_ec[k] = 0; m_fail[k] = 0; m_tmo[k] = 0; m_perr[k] = 0;
            m_age[k] = 0; m_ph[k] = PH_RUN;
          end
          PH_RUN: begin
            m_perr[k] = m_perr[k] | be[k];
            if (abort) m_ph[k] = PH_FIN;
            else if (bd[k]) m_ph[k] = PH_CHECK;
            else if (m_age[k] == p_to(k) - 1) begin
              m_tmo[k] = 1; m_fail[k] = 1; m_ph[k] = PH_FIN;
            end else m_age[k]++;
          end
          PH_CHECK: begin
            bad = m_perr[k] | be[k];
            m_pc[k] = (m_pc[k] + 1) % (p_max(k) + 1);
            if (bad) begin
              m_fail[k] = 1;
              if (m_ec[k] < p_max(k)) m_ec[k]++;
            end
            m_perr[k] = 0;
            if (abort || (m_lim[k] != 0 && m_pc[k] == m_lim[k]) || (p_stop(k) && bad))
              m_ph[k] = PH_FIN;
            else begin
              m_ph[k] = PH_GAP; m_gn[k] = 0;
            end
          end
          PH_GAP: begin
            if (abort) m_ph[k] = PH_FIN;
            else if (m_gn[k] == p_gap(k) - 1) begin
              m_ph[k] = PH_RUN; m_age[k] = 0;
            end else m_gn[k]++;
          end
          default: m_ph[k] = PH_IDLE;
        endcase
      end
    end
  endtask

  task automatic compare();
    for (int k = 0; k < N; k++) begin
      int e_sel, e_busy;
      e_sel  = (m_ph[k] == PH_RUN) ? 1 : 0;
      e_busy = (m_ph[k] != PH_IDLE) ? 1 : 0;
      checks++;
      if (int'(sel[k]) != e_sel || int'(busy[k]) != e_busy || int'(dn[k]) != int'(m_done[k]) ||
          int'(fl[k]) != int'(m_fail[k]) || int'(tm[k]) != int'(m_tmo[k]) ||
          act_pc(k) != m_pc[k] || act_ec(k) != m_ec[k] || act_st(k) != m_ph[k]) begin
        failures++;
        $display("FAIL model_dut%0d t=%0t got sel=%0d busy=%0d done=%0d fail=%0d tmo=%0d pc=%0d ec=%0d st=%0d want sel=%0d busy=%0d done=%0d fail=%0d tmo=%0d pc=%0d ec=%0d st=%0d",
                 k, $time, sel[k], busy[k], dn[k], fl[k], tm[k], act_pc(k), act_ec(k), act_st(k),
                 e_sel, e_busy, m_done[k], m_fail[k], m_tmo[k], m_pc[k], m_ec[k], m_ph[k]);
      end
    end
    sel_hi_cnt += int'(sel[0]);
    done_cnt   += int'(dn[0]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cfg(input int len, input logic [31:0] mask, input bit nz);
    eng_len = len; bad_mask = mask; noise = nz; eng_epoch++;
  endtask

  task automatic pulse_start(input int pl, input int pl2);
    plimit = 8'(pl); plim2 = 2'(pl2); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (busy != '0 && n < budget) begin
      tick();
      n++;
    end
    chk(name, int'(busy), 0);
    tick();
  endtask

  // ---------------- test sequence and scoreboard report ----------------
  initial begin
    int s0, d0, n;
    tlr = 1'b1; start = 1'b0; abort = 1'b0; plimit = '0; plim2 = '0;
    cfg(10, 32'h0, 1'b0);
    fork
      forever begin
        @(posedge clk);
        model_update();
        #1;
        compare();
      end
    join_none

    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_pass_cnt0", int'(pc0), 0);
    chk("rst_state0", int'(st0), 0);
    tlr = 1'b0;
    tick();

    // 1: three clean passes
    s0 = sel_hi_cnt; d0 = done_cnt;
    pulse_start(3, 3);
    wait_idle(200, "t1_idle");
    chk("t1_pass_cnt", int'(pc0), 3);
    chk("t1_err_cnt", int'(ec0), 0);
    chk("t1_fail", int'(fl[0]), 0);
    chk("t1_sel_cycles", sel_hi_cnt - s0, 30);
    chk("t1_done_pulses", done_cnt - d0, 1);
    chk("t1_model_pc", m_pc[0], 3);

    // 2: error in pass 2 only
    cfg(10, 32'h2, 1'b0);
    pulse_start(4, 2);
    wait_idle(200, "t2_idle");
    chk("t2_pass_cnt", int'(pc0), 4);
    chk("t2_err_cnt", int'(ec0), 1);
    chk("t2_fail", int'(fl[0]), 1);
    chk("t2_timeout", int'(tm[0]), 0);
    chk("t2_stop_pass_cnt", int'(pc1), 2);
    chk("t2_stop_err_cnt", int'(ec1), 1);
    chk("t2_cw2_err_cnt", int'(ec2), 1);

    // 3: engine never completes
    cfg(0, 32'h0, 1'b0);
    s0 = sel_hi_cnt; d0 = done_cnt;
    pulse_start(1, 1);
    wait_idle(100, "t3_idle");
    chk("t3_sel_cycles", sel_hi_cnt - s0, 16);
    chk("t3_timeout", int'(tm[0]), 1);
    chk("t3_fail", int'(fl[0]), 1);
    chk("t3_pass_cnt", int'(pc0), 0);
    chk("t3_done_pulses", done_cnt - d0, 1);
    chk("t3_model_tmo", int'(m_tmo[0]), 1);

    // 4: unlimited run, abort mid pass 6
    cfg(6, 32'h0, 1'b0);
    pulse_start(0, 0);
    n = 0;
    while (!(eng_pass[0] == 5 && sel[0] && eng_age[0] >= 3) && n < 400) begin
      tick();
      n++;
    end
    chk("t4_reach_pass6", int'(n < 400), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_finish_state", int'(st0), PH_FIN);
    wait_idle(50, "t4_idle");
    chk("t4_pass_cnt", int'(pc0), 5);
    pulse_start(2, 2);
    chk("t4_restart_pc", int'(pc0), 0);
    chk("t4_restart_busy", int'(busy[0]), 1);
    wait_idle(200, "t4_idle2");
    chk("t4_rerun_pc", int'(pc0), 2);

    // 5: reset in GAP, then in RUN
    cfg(4, 32'h0, 1'b0);
    pulse_start(0, 0);
    n = 0;
    while (m_ph[0] != PH_GAP && n < 100) begin tick(); n++; end
    chk("t5_reach_gap", int'(n < 100), 1);
    tlr = 1'b1;
    tick();
    tlr = 1'b0;
    chk("t5g_sel", int'(sel), 0);
    chk("t5g_busy", int'(busy), 0);
    chk("t5g_pc", int'(pc0), 0);
    chk("t5g_state", int'(st0), 0);
    pulse_start(2, 2);
    wait_idle(200, "t5g_idle");
    chk("t5g_rerun_pc", int'(pc0), 2);
    pulse_start(0, 0);
    n = 0;
    while (!(m_ph[0] == PH_RUN && m_age[0] >= 2) && n < 100) begin tick(); n++; end
    chk("t5_reach_run", int'(n < 100), 1);
    tlr = 1'b1;
    tick();
    tlr = 1'b0;
    chk("t5r_sel", int'(sel), 0);
    chk("t5r_busy", int'(busy), 0);
    chk("t5r_fail", int'(fl[0]), 0);
    pulse_start(1, 1);
    wait_idle(200, "t5r_idle");
    chk("t5r_rerun_pc", int'(pc0), 1);

    // 6: start+abort in idle, start while busy, error saturation
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t6_no_activity", int'(busy), 0);
      tick();
    end
    cfg(5, 32'h0, 1'b0);
    pulse_start(5, 3);
    repeat (8) tick();
    plimit = 8'd1; plim2 = 2'd1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(300, "t6b_idle");
    chk("t6b_pass_cnt", int'(pc0), 5);
    chk("t6b_cw2_pass_cnt", int'(pc2), 3);
    cfg(3, 32'hFFFF_FFFF, 1'b0);
    pulse_start(0, 0);
    n = 0;
    while (eng_pass[2] < 5 && n < 300) begin tick(); n++; end
    chk("t6c_reach_pass5", int'(n < 300), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_idle(50, "t6c_idle");
    chk("t6c_err_sat", int'(ec2), 3);
    chk("t6c_pass_wrap", int'(pc2), 1);
    chk("t6c_fail", int'(fl[2]), 1);
    chk("t6c_stop_pc", int'(pc1), 1);
    chk("t6c_stop_ec", int'(ec1), 1);

    // randomized sequences with noise, aborts, stray starts and resets
    for (int s = 0; s < 40; s++) begin
      cfg(int'($urandom_range(1, 20)), $urandom, 1'b1);
      pulse_start(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
      for (int c = 0; c < 400 && busy != '0; c++) begin
        abort  = ($urandom_range(0, 59) == 0) || (c > 150);
        tlr    = ($urandom_range(0, 249) == 0);
        start  = ($urandom_range(0, 39) == 0);
        plimit = 8'($urandom_range(0, 6));
        plim2  = 2'($urandom_range(0, 3));
        tick();
      end
      abort = 1'b0; tlr = 1'b0; start = 1'b0;
      chk("rand_idle", int'(busy), 0);
      tick();
    end

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
